// File: rtl/piso_reg.sv
// Parallel-in serial-out shift register with valid/ready load and a last-bit marker.
// A new word may be accepted on the last-bit cycle so consecutive words stream gap-free.
module piso_reg #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pdata,
  output logic             q,
  output logic             q_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  shreg_next;
  logic              head;
  logic              accept;

  // The head bit is always the one on q; shifting moves the next bit into that slot.
  always_comb begin
    if (LSB_FIRST != 0) begin
      head       = shreg_q[0];
      shreg_next = {1'b0, shreg_q[WIDTH-1:1]};
    end else begin
      head       = shreg_q[WIDTH-1];
      shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    q_valid    = (state_q == StShift);
    last       = q_valid && (cnt_q == CntLast);
    q          = q_valid && head;
    busy       = q_valid;
    load_ready = !rst && ((state_q == StIdle) || last);
    accept     = load_valid && load_ready;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = StShift;
      shreg_d = pdata;
      cnt_d   = '0;
    end else if (state_q == StShift) begin
      if (last) begin
        state_d = StIdle;
        shreg_d = '0;
        cnt_d   = '0;
      end else begin
        shreg_d = shreg_next;
        cnt_d   = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/piso_reg.md
# piso_reg

Parallel-in serial-out shift register, the transmit-side counterpart of `sipo_reg`. It accepts a WIDTH-bit word through a valid/ready handshake and drives it out one bit per clock on `q`, with a valid qualifier and a last-bit marker. A new word can be accepted on the last-bit cycle, so back-to-back words stream with no gap. It sits upstream of `sipo_reg` in the serial loopback and shift-register verification environment.

## Interface

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- LSB_FIRST, 0, bit order: 0 sends bit WIDTH-1 first, 1 sends bit 0 first.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  a parallel word is offered on `pdata`.
- load_ready  output  1  the block can accept a word this cycle.
- pdata  input  WIDTH  parallel word; sampled only on the accept cycle.
- q  output  1  serial data bit (registered).
- q_valid  output  1  `q` carries a valid bit this cycle (registered).
- last  output  1  the current `q` is the final bit of its word (registered).
- busy  output  1  a word is being shifted out; equals `q_valid`.

## Operation

- The state machine has two states.
  - IDLE: no word is held.
  - SHIFT: a word is held, and a bit counter `cnt` (width clog2(WIDTH)) counts bits already emitted.
- `load_ready` = !rst && (state==IDLE || (state==SHIFT && last)). It is combinational from registered state.
- A word is accepted on a rising edge where load_valid && load_ready. `pdata` is captured into the shift register, `cnt` is cleared, and the state becomes SHIFT.
- In SHIFT, `q` presents the current head bit:
  - the MSB when LSB_FIRST=0;
  - the LSB when LSB_FIRST=1.
- At each edge in SHIFT without an accept, the register shifts by one toward the head and `cnt` increments.
- `last` = 1 when `cnt` == WIDTH-1.
- On the edge leaving the `last` cycle:
  - with an accept, the new word's first bit is on `q` in the next cycle and the state stays SHIFT;
  - without an accept, the state returns to IDLE.
- In IDLE, `q`=0, `q_valid`=0 and `last`=0.
- `load_valid` while `load_ready`=0 is ignored. The word is not queued, and `pdata` changes have no effect on the word in flight.
- Reset, at any time including mid-word, sets on the next edge:
  - state to IDLE;
  - shift register and `cnt` to 0;
  - `q`, `q_valid`, `last` and `busy` to 0.
  
  The partial word is discarded. `load_ready` is 0 while `rst` is high and 1 in the first cycle after `rst` falls.

## Timing

- Latency: the accept is at edge N. Bit 0 of the serial stream is valid in the cycle after edge N, and bit k is valid in the cycle after edge N+k.
- A word occupies exactly WIDTH consecutive valid cycles. `last` is high only in the WIDTH-th cycle.
- Back-to-back: an accept on the `last` cycle gives continuous `q_valid`=1 with no bubble.
- Throughput: one word per WIDTH cycles.
- Simultaneous `rst` and `load_valid`: reset wins and the word is not accepted.
- `load_valid` with `load_ready`=1 in IDLE is accepted on that same edge. There is no extra idle cycle.

## Test plan

- Reset: hold `rst` for 2 cycles, then release.
  - Required: `q`=0, `q_valid`=0, `last`=0, `busy`=0 throughout reset.
  - Required: `load_ready`=0 during reset and 1 on the first cycle after.
- Single word, WIDTH=4, LSB_FIRST=0: accept pdata=4'b1011.
  - Required: `q` = 1,0,1,1 on the next 4 cycles with `q_valid`=1.
  - Required: `last`=1 only on the 4th cycle, then IDLE with `q_valid`=0.
- Bit order, LSB_FIRST=1: accept 4'b1011.
  - Required: `q` = 1,1,0,1.
- Back-to-back: accept 4'b1011, then accept 4'b0110 on its `last` cycle.
  - Required: 8 contiguous valid bits 1,0,1,1,0,1,1,0.
  - Required: `last` high on cycles 4 and 8 only.
- Hold-off: during word 4'b1100, assert `load_valid` with pdata=4'b0011 on cycles 1–2 only.
  - Required: `load_ready`=0 on those cycles.
  - Required: output stays 1,1,0,0, then IDLE with no second word.
- Mid-word reset: accept 4'b1111 and assert `rst` after 2 bits.
  - Required: next cycle `q`=0, `q_valid`=0, `last`=0.
  - Required: after release, accepting 4'b1001 yields 1,0,0,1.
